// File: rtl/i2c_slave_regfile_if.sv
// Local-side bundle of the I2C register-file target: register read port,
// per-byte write strobe and transaction busy flag.
`timescale 1ns/1ps
interface i2c_slave_regfile_if #(
    parameter int unsigned NUM_REGS = 16
);
    localparam int unsigned PW = $clog2(NUM_REGS);

    logic [PW-1:0] loc_addr;
    logic [7:0]    loc_rdata;
    logic          wr_stb;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    modport slave  (input  loc_addr, output loc_rdata, wr_stb, wr_addr, wr_data, busy);
    modport master (output loc_addr, input  loc_rdata, wr_stb, wr_addr, wr_data, busy);
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file and auto-incrementing pointer.
// Define GENERAL_CALL_EN to ACK address 8'h00 and honour the 8'h06 clear command.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h55,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               SCL,
    inout  wire                SDA,
    i2c_slave_regfile_if.slave loc
);
    localparam int unsigned PW = $clog2(NUM_REGS);
    localparam int unsigned CW = $clog2(FILTER_LEN) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WR_DATA, S_WR_ACK,
        S_RD_DATA, S_RD_ACK, S_GC_CMD, S_GC_ACK, S_GC_WAIT
    } state_t;

    logic [1:0] raw, flt_q, flt_d;
    logic       scl_rise, scl_fall, start_c, stop_c, sda_f;

    assign raw = {SDA, SCL};

    // Per-line synchroniser followed by a run-length glitch filter (index 0 = SCL, 1 = SDA)
    for (genvar g = 0; g < 2; g++) begin : g_fe
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt;
        logic                   f;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync_q <= '1;
                cnt    <= '0;
                f      <= 1'b1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
                if (sync_q[SYNC_STAGES-1] == f) begin
                    cnt <= '0;
                end else if (cnt == CW'(FILTER_LEN - 1)) begin
                    f   <= sync_q[SYNC_STAGES-1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
        assign flt_q[g] = f;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) flt_d <= '1;
        else       flt_d <= flt_q;
    end

    assign sda_f    = flt_q[1];
    assign scl_rise =  flt_q[0] & ~flt_d[0];
    assign scl_fall = ~flt_q[0] &  flt_d[0];
    assign start_c  =  flt_d[1] & ~flt_q[1] & flt_q[0] & flt_d[0];
    assign stop_c   = ~flt_d[1] &  flt_q[1] & flt_q[0] & flt_d[0];

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    regs [NUM_REGS];
    logic [PW-1:0] ptr, ptr_inc, wr_addr_q;
    logic [7:0]    wr_data_q, rx_byte;
    logic          ack_q, sda_oe, wr_stb_q, busy_q, gc_hit, addr_hit;

    assign rx_byte = {shift[6:0], sda_f};
    assign ptr_inc = (ptr == PW'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;

`ifdef GENERAL_CALL_EN
    assign gc_hit = (shift == 8'h00);
`else
    assign gc_hit = 1'b0;
`endif
    assign addr_hit = (shift[7:1] == SLAVE_ADDR) || gc_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            ptr       <= '0;
            ack_q     <= 1'b0;
            sda_oe    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_stb_q <= 1'b0;
            // Array update trails the strobe by a cycle so loc_rdata shows the old byte during wr_stb
            if (wr_stb_q) regs[wr_addr_q] <= wr_data_q;
            if (start_c) begin
                state   <= S_ADDR;
                bit_cnt <= '0;
                ack_q   <= 1'b0;
                sda_oe  <= 1'b0;
                busy_q  <= 1'b0;
            end else if (stop_c) begin
                state  <= S_IDLE;
                ack_q  <= 1'b0;
                sda_oe <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_PTR, S_WR_DATA, S_GC_CMD: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            ack_q   <= 1'b0;
                            case (state)
                                S_ADDR: state <= S_ADDR_ACK;
                                S_PTR: begin
                                    ptr   <= rx_byte[PW-1:0];
                                    state <= S_PTR_ACK;
                                end
                                S_WR_DATA: begin
                                    wr_stb_q  <= 1'b1;
                                    wr_addr_q <= ptr;
                                    wr_data_q <= rx_byte;
                                    ptr       <= ptr_inc;
                                    state     <= S_WR_ACK;
                                end
                                default: state <= S_GC_ACK;
                            endcase
                        end
                    end
                    // ACK phases: first SCL fall drives the ACK, second releases it
                    S_ADDR_ACK: if (scl_fall) begin
                        if (!ack_q) begin
                            if (addr_hit) begin
                                ack_q  <= 1'b1;
                                sda_oe <= 1'b1;
                                busy_q <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            ack_q   <= 1'b0;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            if (gc_hit) begin
                                state <= S_GC_CMD;
                            end else if (shift[0]) begin
                                shift  <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                                state  <= S_RD_DATA;
                            end else begin
                                state <= S_PTR;
                            end
                        end
                    end
                    S_PTR_ACK, S_WR_ACK, S_GC_ACK: if (scl_fall) begin
                        if (!ack_q) begin
                            ack_q  <= 1'b1;
                            sda_oe <= 1'b1;
                            if (state == S_GC_ACK && shift == 8'h06) begin
                                for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                                ptr <= '0;
                            end
                        end else begin
                            ack_q   <= 1'b0;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= (state == S_GC_ACK) ? S_GC_WAIT : S_WR_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                ptr    <= ptr_inc;
                                ack_q  <= 1'b0;
                                state  <= S_RD_ACK;
                            end else begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                ack_q <= 1'b1;
                            end
                        end else if (scl_fall && ack_q) begin
                            ack_q   <= 1'b0;
                            bit_cnt <= '0;
                            shift   <= regs[ptr];
                            sda_oe  <= ~regs[ptr][7];
                            state   <= S_RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SDA           = sda_oe ? 1'b0 : 1'bz;
    assign loc.loc_rdata = regs[loc.loc_addr];
    assign loc.wr_stb    = wr_stb_q;
    assign loc.wr_addr   = wr_addr_q;
    assign loc.wr_data   = wr_data_q;
    assign loc.busy      = busy_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master with an open-drain
// SDA model, wr_stb logger and inline checks against hand-computed values.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
    localparam int unsigned NREG = 16;
    localparam int unsigned Q    = 100;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic scl = 1'b1;
    logic m_sda_oe = 1'b0;
    wire  sda;

    int checks = 0;
    int fails  = 0;

    int         wr_cnt = 0;
    logic       pend = 1'b0;
    logic [3:0] log_addr [64];
    logic [7:0] log_data [64];
    logic [7:0] log_old  [64];
    logic [7:0] log_new  [64];

    logic       nak;
    logic [7:0] rd;
    int         base;

    assign sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_regfile_if #(.NUM_REGS(NREG)) loc ();

    i2c_slave_regfile #(
        .SLAVE_ADDR (7'h55),
        .NUM_REGS   (NREG),
        .SYNC_STAGES(2),
        .FILTER_LEN (3)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .SCL (scl),
        .SDA (sda),
        .loc (loc)
    );

    always #5 clk = ~clk;

    // Log every write strobe with loc_rdata during the strobe and one cycle later
    always @(negedge clk) begin
        if (pend) begin
            log_new[wr_cnt-1] = loc.loc_rdata;
            pend = 1'b0;
        end
        if (loc.wr_stb === 1'b1) begin
            log_addr[wr_cnt] = loc.wr_addr;
            log_data[wr_cnt] = loc.wr_data;
            log_old[wr_cnt]  = loc.loc_rdata;
            wr_cnt++;
            pend = 1'b1;
        end
    end

    task automatic bit_out(input logic b);
        m_sda_oe = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic bit_in(output logic b);
        m_sda_oe = 1'b0; #Q; scl = 1'b1; #Q;
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_start;
        m_sda_oe = 1'b0; #Q; scl = 1'b1; #Q; m_sda_oe = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        m_sda_oe = 1'b1; #Q; scl = 1'b1; #Q; m_sda_oe = 1'b0; #Q;
    endtask

    task automatic byte_out(input logic [7:0] d, output logic n);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(n);
    endtask

    task automatic byte_in(input logic n, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(n);
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        loc.loc_addr = a; #1; d = loc.loc_rdata;
    endtask

    task automatic test_reset;
        #20;
        checks++; if (sda !== 1'b1) begin fails++; $display("FAIL reset_sda: got %b expected 1", sda); end
        checks++; if (loc.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", loc.busy); end
        checks++; if (loc.wr_stb !== 1'b0) begin fails++; $display("FAIL reset_wr_stb: got %b expected 0", loc.wr_stb); end
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), rd);
            checks++; if (rd !== 8'h00) begin fails++; $display("FAIL reset_reg%0d: got %h expected 00", i, rd); end
        end
        #30; rstn = 1'b1; #(4*Q);
    endtask

    task automatic test_write;
        logic [3:0] acks;
        base = wr_cnt;
        loc.loc_addr = 4'd3;
        i2c_start;
        byte_out(8'hAA, acks[0]);
        checks++; if (loc.busy !== 1'b1) begin fails++; $display("FAIL write_busy: got %b expected 1", loc.busy); end
        byte_out(8'h03, acks[1]);
        byte_out(8'h11, acks[2]);
        byte_out(8'h22, acks[3]);
        i2c_stop;
        checks++; if (acks !== 4'b0000) begin fails++; $display("FAIL write_acks: got %b expected 0000", acks); end
        checks++; if (wr_cnt - base !== 2) begin fails++; $display("FAIL write_stb_count: got %0d expected 2", wr_cnt - base); end
        checks++; if (log_addr[base] !== 4'd3 || log_data[base] !== 8'h11) begin fails++; $display("FAIL write_stb0: got %h/%h expected 3/11", log_addr[base], log_data[base]); end
        checks++; if (log_addr[base+1] !== 4'd4 || log_data[base+1] !== 8'h22) begin fails++; $display("FAIL write_stb1: got %h/%h expected 4/22", log_addr[base+1], log_data[base+1]); end
        checks++; if (log_old[base] !== 8'h00) begin fails++; $display("FAIL write_same_cycle_old: got %h expected 00", log_old[base]); end
        checks++; if (log_new[base] !== 8'h11) begin fails++; $display("FAIL write_next_cycle_new: got %h expected 11", log_new[base]); end
        read_reg(4'd4, rd);
        checks++; if (rd !== 8'h22) begin fails++; $display("FAIL write_reg4: got %h expected 22", rd); end
        checks++; if (loc.busy !== 1'b0) begin fails++; $display("FAIL write_busy_after_stop: got %b expected 0", loc.busy); end
    endtask

    task automatic test_read;
        logic [3:0] acks;
        i2c_start; byte_out(8'hAA, nak); byte_out(8'h05, nak); byte_out(8'h77, nak); i2c_stop;
        i2c_start;
        byte_out(8'hAA, acks[0]);
        byte_out(8'h03, acks[1]);
        i2c_start;
        byte_out(8'hAB, acks[2]);
        checks++; if (acks[2:0] !== 3'b000) begin fails++; $display("FAIL read_acks: got %b expected 000", acks[2:0]); end
        byte_in(1'b0, rd);
        checks++; if (rd !== 8'h11) begin fails++; $display("FAIL read_byte0: got %h expected 11", rd); end
        byte_in(1'b1, rd);
        checks++; if (rd !== 8'h22) begin fails++; $display("FAIL read_byte1: got %h expected 22", rd); end
        checks++; if (loc.busy !== 1'b0) begin fails++; $display("FAIL read_busy_after_nack: got %b expected 0", loc.busy); end
        checks++; if (sda !== 1'b1) begin fails++; $display("FAIL read_sda_released: got %b expected 1", sda); end
        i2c_stop;
        i2c_start; byte_out(8'hAB, acks[3]); byte_in(1'b1, rd); i2c_stop;
        checks++; if (acks[3] !== 1'b0 || rd !== 8'h77) begin fails++; $display("FAIL read_ptr_at_5: got %b/%h expected 0/77", acks[3], rd); end
    endtask

    task automatic test_wrap;
        base = wr_cnt;
        i2c_start; byte_out(8'hAA, nak); byte_out(8'h0F, nak); byte_out(8'h5A, nak); byte_out(8'hA5, nak); i2c_stop;
        checks++; if (wr_cnt - base !== 2) begin fails++; $display("FAIL wrap_stb_count: got %0d expected 2", wr_cnt - base); end
        checks++; if (log_addr[base] !== 4'hF || log_addr[base+1] !== 4'h0) begin fails++; $display("FAIL wrap_addrs: got %h,%h expected f,0", log_addr[base], log_addr[base+1]); end
        read_reg(4'hF, rd);
        checks++; if (rd !== 8'h5A) begin fails++; $display("FAIL wrap_reg15: got %h expected 5a", rd); end
        read_reg(4'h0, rd);
        checks++; if (rd !== 8'hA5) begin fails++; $display("FAIL wrap_reg0: got %h expected a5", rd); end
        base = wr_cnt;
        i2c_start; byte_out(8'hAA, nak); byte_out(8'h1F, nak); byte_out(8'hC3, nak); i2c_stop;
        checks++; if (wr_cnt - base !== 1 || log_addr[base] !== 4'hF) begin fails++; $display("FAIL wrap_ptr_trunc: got %0d/%h expected 1/f", wr_cnt - base, log_addr[base]); end
        read_reg(4'hF, rd);
        checks++; if (rd !== 8'hC3) begin fails++; $display("FAIL wrap_reg15_trunc: got %h expected c3", rd); end
    endtask

    task automatic test_mismatch;
        base = wr_cnt;
        i2c_start;
        byte_out(8'hA8, nak);
        checks++; if (nak !== 1'b1) begin fails++; $display("FAIL mismatch_nack: got %b expected 1", nak); end
        checks++; if (loc.busy !== 1'b0) begin fails++; $display("FAIL mismatch_busy: got %b expected 0", loc.busy); end
        byte_out(8'h00, nak);
        byte_out(8'h5A, nak);
        i2c_stop;
        checks++; if (wr_cnt !== base) begin fails++; $display("FAIL mismatch_no_stb: got %0d expected %0d", wr_cnt, base); end
    endtask

    task automatic test_glitch;
        // Low glitch on idle bus must not look like START
        @(posedge clk); #2; m_sda_oe = 1'b1; @(posedge clk); #2; m_sda_oe = 1'b0;
        #Q; scl = 1'b0; #Q;
        byte_out(8'hAA, nak);
        checks++; if (nak !== 1'b1) begin fails++; $display("FAIL glitch_no_start: got %b expected 1", nak); end
        i2c_stop;
        // High glitch during a 0 bit with SCL high must not look like STOP
        base = wr_cnt;
        i2c_start; byte_out(8'hAA, nak); byte_out(8'h06, nak);
        m_sda_oe = 1'b1; #Q; scl = 1'b1; #Q;
        @(posedge clk); #2; m_sda_oe = 1'b0; @(posedge clk); #2; m_sda_oe = 1'b1;
        #Q; scl = 1'b0; #Q;
        bit_out(1'b0); bit_out(1'b1); bit_out(1'b1); bit_out(1'b1); bit_out(1'b1); bit_out(1'b0); bit_out(1'b0);
        bit_in(nak);
        i2c_stop;
        checks++; if (nak !== 1'b0) begin fails++; $display("FAIL glitch_no_stop_ack: got %b expected 0", nak); end
        checks++; if (wr_cnt - base !== 1 || log_addr[base] !== 4'd6 || log_data[base] !== 8'h3C) begin fails++; $display("FAIL glitch_write: got %0d/%h/%h expected 1/6/3c", wr_cnt - base, log_addr[base], log_data[base]); end
    endtask

    task automatic test_abort;
        i2c_start; byte_out(8'hAA, nak); byte_out(8'h07, nak); byte_out(8'h99, nak); i2c_stop;
        base = wr_cnt;
        i2c_start; byte_out(8'hAA, nak); byte_out(8'h07, nak);
        bit_out(1'b1); bit_out(1'b1); bit_out(1'b1); bit_out(1'b1);
        i2c_stop;
        checks++; if (wr_cnt !== base) begin fails++; $display("FAIL abort_no_stb: got %0d expected %0d", wr_cnt, base); end
        read_reg(4'd7, rd);
        checks++; if (rd !== 8'h99) begin fails++; $display("FAIL abort_reg7: got %h expected 99", rd); end
        i2c_start; byte_out(8'hAB, nak); byte_in(1'b1, rd); i2c_stop;
        checks++; if (rd !== 8'h99) begin fails++; $display("FAIL abort_ptr_kept: got %h expected 99", rd); end
    endtask

    task automatic test_general_call;
        i2c_start;
        byte_out(8'h00, nak);
`ifdef GENERAL_CALL_EN
        checks++; if (nak !== 1'b0) begin fails++; $display("FAIL gc_addr_ack: got %b expected 0", nak); end
        byte_out(8'h06, nak);
        checks++; if (nak !== 1'b0) begin fails++; $display("FAIL gc_cmd_ack: got %b expected 0", nak); end
        i2c_stop;
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), rd);
            checks++; if (rd !== 8'h00) begin fails++; $display("FAIL gc_clear_reg%0d: got %h expected 00", i, rd); end
        end
`else
        checks++; if (nak !== 1'b1) begin fails++; $display("FAIL gc_addr_nack: got %b expected 1", nak); end
        i2c_stop;
        read_reg(4'hF, rd);
        checks++; if (rd !== 8'hC3) begin fails++; $display("FAIL gc_reg15_kept: got %h expected c3", rd); end
`endif
    endtask

    task automatic test_reset_mid;
        logic [7:0] a;
        a = 8'hAA;
        i2c_start;
        for (int i = 7; i >= 0; i--) bit_out(a[i]);
        m_sda_oe = 1'b0; #Q; scl = 1'b1; #Q;
        checks++; if (sda !== 1'b0 || loc.busy !== 1'b1) begin fails++; $display("FAIL midreset_pre_ack: got %b/%b expected 0/1", sda, loc.busy); end
        rstn = 1'b0; #1;
        checks++; if (sda !== 1'b1) begin fails++; $display("FAIL midreset_sda: got %b expected 1", sda); end
        checks++; if (loc.busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", loc.busy); end
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), rd);
            checks++; if (rd !== 8'h00) begin fails++; $display("FAIL midreset_reg%0d: got %h expected 00", i, rd); end
        end
        #Q; rstn = 1'b1; #(2*Q);
    endtask

    initial begin
        loc.loc_addr = '0;
        test_reset;
        test_write;
        test_read;
        test_wrap;
        test_mismatch;
        test_glitch;
        test_abort;
        test_general_call;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
